vga_fb_fill_master: RTL and testbench
=====================================

Name: vga_fb_fill_master

Overview:
- AXI4 write master that sequences full-frame fills of the VGA frame buffer (RGB565, two pixels per 32-bit word) behind the CDC VGA AXI slave.
- Used at boot and on software request to clear the screen or paint test patterns without CPU involvement.
- Sits on the ACLK side, in front of the interconnect port that feeds the VGA slave.
- Issues fixed-length INCR bursts with one burst outstanding, and reports completion and errors.

Parameters:
- C_M_AXI_ID_WIDTH, 12, AWID/BID width.
- C_M_AXI_ADDR_WIDTH, 17, byte address width.
- BURST_LEN, 16, beats per burst (1..256); FB_WORDS must be a multiple of it.
- FB_WORDS, 32768, 32-bit words per frame.
- FB_BASE, 0, byte base address of the frame buffer.

Ports:
- ACLK  in  1  clock.
- reset_aclk  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle request to begin a fill; ignored while busy.
- abort  in  1  level; request early termination.
- mode  in  2  0 solid, 1 word-index ramp, 2 checkerboard, 3 same as 0.
- color  in  16  RGB565 fill colour.
- busy  out  1  high from the cycle after start until the cycle done pulses.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  last fill ended by abort; held until next start.
- err  out  1  sticky: a BRESP was not OKAY during the current fill; cleared by start.
- M_AXI_AWID  out  C_M_AXI_ID_WIDTH  constant 0.
- M_AXI_AWADDR  out  C_M_AXI_ADDR_WIDTH  burst byte address.
- M_AXI_AWLEN  out  8  BURST_LEN-1.
- M_AXI_AWSIZE  out  3  3'b010.
- M_AXI_AWBURST  out  2  2'b01 (INCR).
- M_AXI_AWVALID / M_AXI_AWREADY  out / in  1  AW handshake.
- M_AXI_WDATA  out  32  pixel pair.
- M_AXI_WSTRB  out  4  4'hF.
- M_AXI_WLAST  out  1  last beat of a burst.
- M_AXI_WVALID / M_AXI_WREADY  out / in  1  W handshake.
- M_AXI_BID  in  C_M_AXI_ID_WIDTH  ignored.
- M_AXI_BRESP  in  2  write response.
- M_AXI_BVALID / M_AXI_BREADY  in / out  1  B handshake.

Behaviour:
- Reset values: all outputs 0, except constant fields (AWLEN, AWSIZE, AWBURST, WSTRB). State returns to IDLE immediately on reset_aclk, including mid-burst; no AXI completion is attempted.
- FSM states: IDLE, ADDR, DATA, RESP, FIN.
- IDLE: start=1 latches mode and color, clears burst_idx, err and aborted, sets busy, and moves to ADDR on the next cycle.
- ADDR: AWVALID=1; AWADDR = FB_BASE + burst_idx*BURST_LEN*4, truncated to address width. AWVALID and AWADDR are held stable until AWREADY. On the handshake, beat=0 and the FSM goes to DATA.
- DATA: WVALID=1. WDATA and WLAST stay stable while WREADY=0. WLAST = (beat==BURST_LEN-1). Each handshake increments beat and word_idx. After the WLAST handshake the FSM goes to RESP.
- W is never issued before the matching AW handshake completes; AW and W are never valid together.
- RESP: BREADY=1. On BVALID, BRESP!=2'b00 sets err. Then:
  - if abort=1, or burst_idx was the last (FB_WORDS/BURST_LEN-1): go to FIN, setting aborted if abort=1 and this was not the last burst;
  - else increment burst_idx and go to ADDR.
- abort is sampled only in RESP, so an in-flight burst always completes and the AXI protocol stays legal.
- FIN: done=1 for exactly one cycle, busy drops in the same cycle, then IDLE. A start during FIN is ignored.
- word_idx = burst_idx*BURST_LEN + beat (16-bit wrap allowed).
- WDATA by mode:
  - mode 0 / 3: {color, color}.
  - mode 1: {word_idx[15:0], word_idx[15:0]}.
  - mode 2: sel = word_idx[3] XOR word_idx[10]; both halves = sel ? ~color : color.
- Throughput: 1 beat/cycle when WREADY is held high. Minimum burst overhead is 1 AW cycle plus 1 B cycle.

Test Plan:
- Ready/valid always high, BURST_LEN=16, FB_WORDS=64, mode 0, color=16'hF800, start pulse → 4 bursts with AWADDR 0x00, 0x40, 0x80, 0xC0, AWLEN=15; every WDATA=32'hF800F800; WLAST on beats 15/31/47/63; done pulses once; err=0, aborted=0.
- Mode 1 with random AWREADY/WREADY/BVALID stalls → WDATA sequence 0x00000000, 0x00010001 … 0x003F003F; no WDATA/AWADDR change while stalled; 64 W handshakes in total.
- Mode 2, color=16'h07E0, FB_WORDS=2048 → word 0 = 32'h07E007E0, word 8 = 32'hF81FF81F, word 1024 = 32'hF81FF81F, word 1032 = 32'h07E007E0.
- Abort asserted during beat 5 of burst 1 → burst 1 completes all 16 beats and its B response; no further AW; done pulses; aborted=1.
- BRESP=2'b10 on burst 2 → fill continues to completion, err=1 at done; next start clears err to 0.
- reset_aclk asserted mid-DATA → AWVALID, WVALID, BREADY and busy are 0 immediately; start pulses during busy are ignored (burst count unchanged).

Source files
------------

// File: rtl/vga_fb_fill_master.sv
// rtl/vga_fb_fill_master.sv - AXI4 write master that fills the VGA frame buffer with a pattern
//
// Fills the whole frame buffer (RGB565, two pixels per 32-bit word) using
// fixed-length INCR bursts, one burst outstanding at a time.
//
// Ports:
//   ACLK, reset_aclk     clock, asynchronous active-high reset
//   start                one-cycle fill request (ignored while busy)
//   abort                level; stops the fill after the burst in flight
//   mode, color          pattern select and RGB565 colour, latched at start
//   busy, done           fill in progress / one-cycle completion pulse
//   aborted, err         fill ended early / a BRESP was not OKAY
//   M_AXI_AW*, M_AXI_W*, M_AXI_B*   AXI4 write address, data and response channels

module vga_fb_fill_master #(
    parameter int C_M_AXI_ID_WIDTH   = 12,
    parameter int C_M_AXI_ADDR_WIDTH = 17,
    parameter int BURST_LEN          = 16,
    parameter int FB_WORDS           = 32768,
    parameter int FB_BASE            = 0
) (
    input  logic                          ACLK,
    input  logic                          reset_aclk,
    input  logic                          start,
    input  logic                          abort,
    input  logic [1:0]                    mode,
    input  logic [15:0]                   color,
    output logic                          busy,
    output logic                          done,
    output logic                          aborted,
    output logic                          err,
    output logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [7:0]                    M_AXI_AWLEN,
    output logic [2:0]                    M_AXI_AWSIZE,
    output logic [1:0]                    M_AXI_AWBURST,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [31:0]                   M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WLAST,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_BID,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY
);

    localparam int NBURST = FB_WORDS / BURST_LEN;
    localparam int BW     = (NBURST > 1) ? $clog2(NBURST) : 1;
    // Beat counter is one value wider than needed for non-power-of-two
    // lengths, so the post-WLAST increment never aliases a live beat.
    localparam int CW     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int AW     = C_M_AXI_ADDR_WIDTH;

    localparam logic [BW-1:0] LAST_BURST = BW'(NBURST - 1);
    localparam logic [CW-1:0] LAST_BEAT  = CW'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP,
        S_FIN
    } state_t;

    state_t state, state_nxt;

    logic [BW-1:0] burst_idx;
    logic [CW-1:0] beat;
    logic [1:0]    mode_r;
    logic [15:0]   color_r;
    logic          err_r;
    logic          aborted_r;
    logic [15:0]   word_idx;
    logic [15:0]   half;
    logic          last_burst;
    logic          last_beat;

    // Response ID is not needed with a single outstanding burst.
    logic unused_bid;
    assign unused_bid = ^M_AXI_BID;

    assign last_burst = (burst_idx == LAST_BURST);
    assign last_beat  = (beat == LAST_BEAT);

    // Word index within the frame; wraps at 16 bits for the ramp pattern.
    assign word_idx = 16'(burst_idx) * 16'(BURST_LEN) + 16'(beat);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or posedge reset_aclk) begin
        if (reset_aclk) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        busy          = 1'b0;
        done          = 1'b0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_WLAST   = 1'b0;
        M_AXI_BREADY  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                busy          = 1'b1;
                M_AXI_AWVALID = 1'b1;
                if (M_AXI_AWREADY) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                busy         = 1'b1;
                M_AXI_WVALID = 1'b1;
                M_AXI_WLAST  = last_beat;
                if (M_AXI_WREADY && last_beat) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                busy         = 1'b1;
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) begin
                    state_nxt = (abort || last_burst) ? S_FIN : S_ADDR;
                end
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: counters, latched pattern settings and status flags
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or posedge reset_aclk) begin
        if (reset_aclk) begin
            burst_idx <= '0;
            beat      <= '0;
            mode_r    <= 2'd0;
            color_r   <= 16'd0;
            err_r     <= 1'b0;
            aborted_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_r    <= mode;
                        color_r   <= color;
                        burst_idx <= '0;
                        beat      <= '0;
                        err_r     <= 1'b0;
                        aborted_r <= 1'b0;
                    end
                end
                S_ADDR: begin
                    if (M_AXI_AWREADY) begin
                        beat <= '0;
                    end
                end
                S_DATA: begin
                    if (M_AXI_WREADY) begin
                        beat <= beat + 1'b1;
                    end
                end
                S_RESP: begin
                    if (M_AXI_BVALID) begin
                        if (M_AXI_BRESP != 2'b00) begin
                            err_r <= 1'b1;
                        end
                        if (abort || last_burst) begin
                            // An abort arriving with the final burst is a normal completion.
                            aborted_r <= abort && !last_burst;
                        end else begin
                            burst_idx <= burst_idx + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pattern generation and constant AXI fields
    // ------------------------------------------------------------------
    always_comb begin
        half = color_r;
        case (mode_r)
            2'd1:    half = word_idx;
            // 8-word by 1024-word checkerboard tiles.
            2'd2:    half = (word_idx[3] ^ word_idx[10]) ? ~color_r : color_r;
            default: half = color_r;
        endcase
    end

    assign M_AXI_WDATA   = {half, half};
    assign M_AXI_AWADDR  = AW'(FB_BASE) + AW'(burst_idx) * AW'(BURST_LEN * 4);
    assign M_AXI_AWID    = '0;
    assign M_AXI_AWLEN   = 8'(BURST_LEN - 1);
    assign M_AXI_AWSIZE  = 3'b010;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_WSTRB   = 4'hF;
    assign err           = err_r;
    assign aborted       = aborted_r;

endmodule

// File: tb/tb_vga_fb_fill_master.sv
// tb/tb_vga_fb_fill_master.sv - self-checking bench for vga_fb_fill_master

module tb_vga_fb_fill_master;

    localparam int BL  = 16;
    localparam int FW  = 2048;
    localparam int IDW = 12;
    localparam int ADW = 17;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [1:0]      mode = 2'd0;
    logic [15:0]     color = 16'd0;
    logic            busy, done, aborted, err;
    logic [IDW-1:0]  awid;
    logic [ADW-1:0]  awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready = 1'b0;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast, wvalid;
    logic            wready = 1'b0;
    logic [IDW-1:0]  bid = '0;
    logic [1:0]      bresp = 2'b00;
    logic            bvalid = 1'b0;
    logic            bready;

    vga_fb_fill_master #(
        .C_M_AXI_ID_WIDTH  (IDW),
        .C_M_AXI_ADDR_WIDTH(ADW),
        .BURST_LEN         (BL),
        .FB_WORDS          (FW),
        .FB_BASE           (0)
    ) dut (
        .ACLK         (clk),
        .reset_aclk   (rst),
        .start        (start),
        .abort        (abort),
        .mode         (mode),
        .color        (color),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .err          (err),
        .M_AXI_AWID   (awid),
        .M_AXI_AWADDR (awaddr),
        .M_AXI_AWLEN  (awlen),
        .M_AXI_AWSIZE (awsize),
        .M_AXI_AWBURST(awburst),
        .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA  (wdata),
        .M_AXI_WSTRB  (wstrb),
        .M_AXI_WLAST  (wlast),
        .M_AXI_WVALID (wvalid),
        .M_AXI_WREADY (wready),
        .M_AXI_BID    (bid),
        .M_AXI_BRESP  (bresp),
        .M_AXI_BVALID (bvalid),
        .M_AXI_BREADY (bready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    bit stall_en = 1'b0;
    int err_burst = -1;
    int abort_at = -1;

    logic [ADW-1:0] aw_q[$];
    logic [31:0]    w_q[$];
    logic           wl_q[$];
    int done_cnt = 0;
    int busy_cyc = 0;
    int b_hs_cnt = 0;
    int stab_bad = 0;
    int proto_bad = 0;
    int const_bad = 0;

    initial begin
        forever #5 clk = ~clk;
    end

    // Slave: random readiness, one B response per completed burst.
    initial begin
        int pending;
        bit wl_hs, b_hs;
        pending = 0;
        forever begin
            @(negedge clk);
            wl_hs = wvalid && wready && wlast;
            b_hs  = bvalid && bready;
            @(posedge clk);
            #1;
            if (rst) begin
                pending = 0;
                awready = 1'b0;
                wready  = 1'b0;
                bvalid  = 1'b0;
                bresp   = 2'b00;
            end else begin
                pending = pending + int'(wl_hs) - int'(b_hs);
                awready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
                wready  = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (!(bvalid && !b_hs)) begin
                    bvalid = (pending > 0) && (!stall_en || ($urandom_range(0, 2) != 0));
                end
                bresp = (b_hs_cnt == err_burst) ? 2'b10 : 2'b00;
            end
        end
    end

    // Monitor: records handshakes and protocol violations away from the active edge.
    initial begin
        bit             aw_stall, w_stall, wl_hold;
        logic [ADW-1:0] aw_hold;
        logic [31:0]    w_hold;
        aw_stall = 1'b0;
        w_stall  = 1'b0;
        wl_hold  = 1'b0;
        aw_hold  = '0;
        w_hold   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_stall = 1'b0;
                w_stall  = 1'b0;
            end else begin
                if (awvalid && awready) begin
                    aw_q.push_back(awaddr);
                    if (awlen != 8'(BL - 1) || awsize != 3'b010 || awburst != 2'b01 || awid != '0)
                        const_bad++;
                end
                if (wvalid && wready) begin
                    w_q.push_back(wdata);
                    wl_q.push_back(wlast);
                    if (wstrb != 4'hF) const_bad++;
                end
                if (awvalid && wvalid) proto_bad++;
                if (aw_stall && !(awvalid && awaddr == aw_hold)) stab_bad++;
                if (w_stall && !(wvalid && wdata == w_hold && wlast == wl_hold)) stab_bad++;
                aw_stall = awvalid && !awready;
                aw_hold  = awaddr;
                w_stall  = wvalid && !wready;
                w_hold   = wdata;
                wl_hold  = wlast;
                if (done) done_cnt++;
                if (busy) busy_cyc++;
                if (bvalid && bready) b_hs_cnt++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference pattern: word i of a frame for a given mode and colour.
    function automatic logic [31:0] model_word(input logic [1:0] m, input logic [15:0] c, input int i);
        int w;
        logic [15:0] h;
        w = i % 65536;
        case (m)
            2'd1:    h = 16'(w);
            2'd2:    h = (((w / 8) % 2) != ((w / 1024) % 2)) ? ~c : c;
            default: h = c;
        endcase
        return {h, h};
    endfunction

    task automatic run_fill(input logic [1:0] m, input logic [15:0] c, input bit extra_starts);
        @(posedge clk);
        #1;
        aw_q.delete();
        w_q.delete();
        wl_q.delete();
        done_cnt  = 0;
        busy_cyc  = 0;
        b_hs_cnt  = 0;
        stab_bad  = 0;
        proto_bad = 0;
        const_bad = 0;
        mode  = m;
        color = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Scramble the pattern inputs: the fill must use the latched values.
        mode  = 2'($urandom);
        color = 16'($urandom);
        chk("busy_after_start", 64'(busy), 64'(1));
        for (int cyc = 0; cyc < 40000 && done_cnt == 0; cyc++) begin
            @(negedge clk);
            if (extra_starts) start = (cyc == 100 || cyc == 700);
            if (abort_at >= 0 && w_q.size() >= abort_at) abort = 1'b1;
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic check_fill(input string tag, input logic [1:0] m, input logic [15:0] c, input int nw);
        int bad_w, bad_a;
        bad_w = 0;
        bad_a = 0;
        foreach (w_q[i]) begin
            if (w_q[i] !== model_word(m, c, i) || wl_q[i] !== ((i % BL) == BL - 1)) bad_w++;
        end
        foreach (aw_q[i]) begin
            if (aw_q[i] !== ADW'(i * BL * 4)) bad_a++;
        end
        chk({tag, " w_count"},     64'(w_q.size()),  64'(nw));
        chk({tag, " w_errors"},    64'(bad_w),       64'(0));
        chk({tag, " aw_count"},    64'(aw_q.size()), 64'(nw / BL));
        chk({tag, " aw_errors"},   64'(bad_a),       64'(0));
        chk({tag, " b_count"},     64'(b_hs_cnt),    64'(nw / BL));
        chk({tag, " done_pulses"}, 64'(done_cnt),    64'(1));
        chk({tag, " stall_stab"},  64'(stab_bad),    64'(0));
        chk({tag, " aw_w_overlap"},64'(proto_bad),   64'(0));
        chk({tag, " const_fields"},64'(const_bad),   64'(0));
        chk({tag, " busy_end"},    64'(busy),        64'(0));
    endtask

    initial begin
        logic [15:0] c;
        int guard;

        // Reset state
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst awvalid", 64'(awvalid), 64'(0));
        chk("rst wvalid",  64'(wvalid),  64'(0));
        chk("rst bready",  64'(bready),  64'(0));
        chk("rst busy",    64'(busy),    64'(0));
        chk("rst done",    64'(done),    64'(0));
        chk("rst aborted", 64'(aborted), 64'(0));
        chk("rst err",     64'(err),     64'(0));
        chk("rst awaddr",  64'(awaddr),  64'(0));
        chk("rst wdata",   64'(wdata),   64'(0));
        chk("rst wlast",   64'(wlast),   64'(0));
        chk("rst awid",    64'(awid),    64'(0));
        chk("rst awlen",   64'(awlen),   64'(BL - 1));
        chk("rst awsize",  64'(awsize),  64'(2));
        chk("rst awburst", 64'(awburst), 64'(1));
        chk("rst wstrb",   64'(wstrb),   64'(15));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Solid fill, no stalls, extra start pulses while busy
        stall_en = 1'b0;
        run_fill(2'd0, 16'hF800, 1'b1);
        check_fill("solid", 2'd0, 16'hF800, FW);
        chk("solid busy_cycles", 64'(busy_cyc), 64'((FW / BL) * (BL + 2)));
        chk("solid word0",   64'(w_q[0]),  64'(32'hF800F800));
        chk("solid awaddr1", 64'(aw_q[1]), 64'(32'h40));
        chk("solid awaddr3", 64'(aw_q[3]), 64'(32'hC0));
        chk("solid wlast15", 64'(wl_q[15]), 64'(1));
        chk("solid wlast14", 64'(wl_q[14]), 64'(0));
        chk("solid err",     64'(err),     64'(0));
        chk("solid aborted", 64'(aborted), 64'(0));
        chk("solid done_low",64'(done),    64'(0));

        // Ramp with random stalls
        stall_en = 1'b1;
        c = 16'($urandom);
        run_fill(2'd1, c, 1'b0);
        check_fill("ramp", 2'd1, c, FW);
        chk("ramp word1",  64'(w_q[1]),  64'(32'h00010001));
        chk("ramp word63", 64'(w_q[63]), 64'(32'h003F003F));

        // Checkerboard
        run_fill(2'd2, 16'h07E0, 1'b0);
        check_fill("checker", 2'd2, 16'h07E0, FW);
        chk("checker word0",    64'(w_q[0]),    64'(32'h07E007E0));
        chk("checker word8",    64'(w_q[8]),    64'(32'hF81FF81F));
        chk("checker word1024", 64'(w_q[1024]), 64'(32'hF81FF81F));
        chk("checker word1032", 64'(w_q[1032]), 64'(32'h07E007E0));

        // SLVERR on burst 2: fill completes, err sticky
        err_burst = 2;
        c = 16'($urandom);
        run_fill(2'd3, c, 1'b0);
        err_burst = -1;
        check_fill("slverr", 2'd3, c, FW);
        chk("slverr err",     64'(err),     64'(1));
        chk("slverr aborted", 64'(aborted), 64'(0));

        // Next start clears err
        c = 16'($urandom);
        run_fill(2'd0, c, 1'b0);
        check_fill("clear_err", 2'd0, c, FW);
        chk("clear_err err", 64'(err), 64'(0));

        // Abort during beat 5 of burst 1
        abort_at = BL + 5;
        c = 16'($urandom);
        run_fill(2'd1, c, 1'b0);
        abort_at = -1;
        check_fill("abort", 2'd1, c, 2 * BL);
        chk("abort aborted", 64'(aborted), 64'(1));
        chk("abort err",     64'(err),     64'(0));
        repeat (5) @(negedge clk);
        chk("abort aborted_held", 64'(aborted), 64'(1));
        chk("abort no_more_aw",   64'(aw_q.size()), 64'(2));

        // Next start clears aborted
        c = 16'($urandom);
        run_fill(2'd2, c, 1'b0);
        check_fill("after_abort", 2'd2, c, FW);
        chk("after_abort aborted", 64'(aborted), 64'(0));

        // Reset mid-DATA
        @(posedge clk);
        #1;
        w_q.delete();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard = 0;
        while (w_q.size() < 5 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("midrst reached_data", 64'(w_q.size() >= 5), 64'(1));
        rst = 1'b1;
        #1;
        chk("midrst awvalid", 64'(awvalid), 64'(0));
        chk("midrst wvalid",  64'(wvalid),  64'(0));
        chk("midrst bready",  64'(bready),  64'(0));
        chk("midrst busy",    64'(busy),    64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("postrst busy",    64'(busy),    64'(0));
        chk("postrst awvalid", 64'(awvalid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
